// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receive controller and its FIFO.
//   rx_ctrl_state_t  : controller FSM states
//   uart_cfg_t       : frame configuration driven to uart_rx
//   UART_OSR         : oversample ratio of the receiver clock
//   UART_MAX_FRAME_TICKS : longest frame (start + 8 data + parity + 2 stop) in ticks
//   UART_CFG_DEFAULT : configuration after reset (8N1)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    RX_OFF   = 2'd0,
    RX_ARMED = 2'd1,
    RX_BUSY  = 2'd2,
    RX_ABORT = 2'd3
  } rx_ctrl_state_t;

  typedef struct packed {
    logic [3:0] len;
    logic       parity_en;
    logic       parity_ty;
    logic       stop2;
  } uart_cfg_t;

  localparam int UART_OSR             = 16;
  localparam int UART_MAX_FRAME_TICKS = 12 * UART_OSR;

  localparam uart_cfg_t UART_CFG_DEFAULT = '{
    len:       4'd8,
    parity_en: 1'b0,
    parity_ty: 1'b0,
    stop2:     1'b0
  };

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO holding received characters with their error flag.
//   clk, rst   : clock, synchronous active-high reset (empties FIFO, clears array)
//   push       : write push_data; dropped when full unless a pop happens too
//   push_data  : entry to write
//   pop        : advance head; ignored when empty
//   pop_data   : head entry (array read at the registered read pointer)
//   full/empty : registered status flags
//   count      : registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             empty_q;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot the simultaneous push needs, so a full FIFO
  // accepts a push only when it is also being popped.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    count_next = count_q;
    if (do_push && !do_pop) begin
      count_next = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == FULL_CNT);
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Sequences one uart_rx: holds its frame configuration, arms it, supervises
// each frame with a watchdog, aborts it on disable or timeout, and queues each
// received character {er, data} in a FIFO for the consumer.
//   i_rx_clk, rst          : 16x oversample clock, synchronous active-high reset
//   i_en                   : reception enable
//   i_cfg_wr, i_cfg_*      : config write (accepted only in OFF)
//   o_len .. o_stop2       : registered config to uart_rx
//   o_rx_str, o_rx_rst     : arm strobe / reset to uart_rx
//   i_line                 : raw serial line (start-bit detection)
//   i_rx_data/done/er      : uart_rx result
//   o_data, o_valid, i_ready, o_count : FIFO head, non-empty, pop, occupancy
//   o_overrun, o_timeout, i_flag_clr  : sticky flags and their clear
//   o_busy                 : frame in progress (BUSY or ABORT)
//   o_state                : current FSM state, for observation
//
// Handshake: o_data is valid whenever o_valid is high; an entry is consumed on
// every rising edge where o_valid and i_ready are both high. i_ready while
// o_valid is low has no effect.
//
// TIMEOUT must be at least UART_MAX_FRAME_TICKS so a legal frame never trips
// the watchdog; DEPTH must be a power of two >= 2.
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                   i_rx_clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_cfg_wr,
  input  logic [3:0]             i_cfg_len,
  input  logic                   i_cfg_parity_en,
  input  logic                   i_cfg_parity_ty,
  input  logic                   i_cfg_stop2,
  output logic [3:0]             o_len,
  output logic                   o_parity_en,
  output logic                   o_parity_ty,
  output logic                   o_stop2,
  output logic                   o_rx_str,
  output logic                   o_rx_rst,
  input  logic                   i_line,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_rx_er,
  output logic [8:0]             o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overrun,
  output logic                   o_timeout,
  input  logic                   i_flag_clr,
  output logic                   o_busy,
  output rx_ctrl_state_t         o_state
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  rx_ctrl_state_t  state;
  uart_cfg_t       cfg;
  logic [WD_W-1:0] wd;
  logic            rx_str_q;
  logic            busy_q;
  logic            timeout_q;
  logic            overrun_q;

  logic            push;
  logic            drop;
  logic            wd_expired;
  logic            fifo_full;
  logic            fifo_empty;

  // Only a done seen during a supervised frame is queued.
  assign push       = (state == RX_BUSY) && i_rx_done;
  // Full implies non-empty, so a simultaneous pop always makes room.
  assign drop       = push && fifo_full && !i_ready;
  // Done in the last watchdog cycle still completes the frame.
  assign wd_expired = (state == RX_BUSY) && !i_rx_done && (wd == WD_LAST);

  // Controller FSM with registered strobe, busy and timeout outputs.
  always_ff @(posedge i_rx_clk) begin
    if (rst) begin
      state     <= RX_OFF;
      cfg       <= UART_CFG_DEFAULT;
      wd        <= '0;
      rx_str_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RX_OFF: begin
          if (i_cfg_wr) begin
            cfg <= '{len: i_cfg_len, parity_en: i_cfg_parity_en,
                     parity_ty: i_cfg_parity_ty, stop2: i_cfg_stop2};
          end
          if (i_en) begin
            state    <= RX_ARMED;
            rx_str_q <= 1'b1;
          end
        end
        RX_ARMED: begin
          if (!i_en) begin
            state    <= RX_OFF;
            rx_str_q <= 1'b0;
          end else if (!i_line) begin
            // Same edge on which uart_rx leaves idle on the start bit.
            state  <= RX_BUSY;
            wd     <= '0;
            busy_q <= 1'b1;
          end
        end
        RX_BUSY: begin
          wd <= wd + 1'b1;
          if (i_rx_done) begin
            state  <= RX_ARMED;
            busy_q <= 1'b0;
          end else if (!i_en || wd_expired) begin
            state    <= RX_ABORT;
            rx_str_q <= 1'b0;
          end
        end
        RX_ABORT: begin
          busy_q <= 1'b0;
          if (i_en) begin
            state    <= RX_ARMED;
            rx_str_q <= 1'b1;
          end else begin
            state <= RX_OFF;
          end
        end
        default: begin
          state    <= RX_OFF;
          rx_str_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase

      // Set beats clear when both happen in one cycle.
      if (wd_expired) begin
        timeout_q <= 1'b1;
      end else if (i_flag_clr) begin
        timeout_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_rx_clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (i_flag_clr) begin
      overrun_q <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_rx_clk),
    .rst       (rst),
    .push      (push),
    .push_data ({i_rx_er, i_rx_data}),
    .pop       (i_ready),
    .pop_data  (o_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  assign o_len       = cfg.len;
  assign o_parity_en = cfg.parity_en;
  assign o_parity_ty = cfg.parity_ty;
  assign o_stop2     = cfg.stop2;
  assign o_rx_str    = rx_str_q;
  assign o_rx_rst    = rst || (state == RX_ABORT);
  assign o_valid     = !fifo_empty;
  assign o_overrun   = overrun_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = busy_q;
  assign o_state     = state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl (DEPTH=4, TIMEOUT=256). The uart_rx side is
// played by the bench: i_line starts a frame, i_rx_done/i_rx_data/i_rx_er end it.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           i_en = 0, i_cfg_wr = 0, i_cfg_parity_en = 0, i_cfg_parity_ty = 0, i_cfg_stop2 = 0;
  logic [3:0]     i_cfg_len = 4'd8;
  logic           i_line = 1, i_rx_done = 0, i_rx_er = 0, i_ready = 0, i_flag_clr = 0;
  logic [7:0]     i_rx_data = 8'h00;
  logic [3:0]     o_len;
  logic           o_parity_en, o_parity_ty, o_stop2, o_rx_str, o_rx_rst;
  logic [8:0]     o_data;
  logic           o_valid, o_overrun, o_timeout, o_busy;
  logic [2:0]     o_count;
  rx_ctrl_state_t o_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;

  uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_rx_clk(clk), .rst(rst), .i_en(i_en), .i_cfg_wr(i_cfg_wr),
    .i_cfg_len(i_cfg_len), .i_cfg_parity_en(i_cfg_parity_en),
    .i_cfg_parity_ty(i_cfg_parity_ty), .i_cfg_stop2(i_cfg_stop2),
    .o_len(o_len), .o_parity_en(o_parity_en), .o_parity_ty(o_parity_ty),
    .o_stop2(o_stop2), .o_rx_str(o_rx_str), .o_rx_rst(o_rx_rst),
    .i_line(i_line), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_rx_er(i_rx_er), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_count(o_count), .o_overrun(o_overrun), .o_timeout(o_timeout),
    .i_flag_clr(i_flag_clr), .o_busy(o_busy), .o_state(o_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic write_cfg(input logic [3:0] len, input logic pe, input logic pt, input logic s2);
    i_cfg_wr = 1; i_cfg_len = len; i_cfg_parity_en = pe; i_cfg_parity_ty = pt; i_cfg_stop2 = s2;
    tick(1);
    i_cfg_wr = 0;
  endtask

  // Start bit, then `len` cycles of frame, then a one-cycle done.
  task automatic send_frame(input logic [7:0] d, input logic er, input int len);
    i_line = 0;
    tick(1);
    i_line = 1;
    tick(len);
    i_rx_data = d; i_rx_er = er; i_rx_done = 1;
    tick(1);
    i_rx_done = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1;
    tick(2);
    n_checks++; if (o_state !== RX_OFF) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", o_state, RX_OFF); end
    n_checks++; if (o_rx_str !== 1'b0) begin n_fail++; $display("FAIL reset_rx_str: got %b expected 0", o_rx_str); end
    n_checks++; if (o_rx_rst !== 1'b1) begin n_fail++; $display("FAIL reset_rx_rst: got %b expected 1", o_rx_rst); end
    n_checks++; if ({o_len, o_parity_en, o_parity_ty, o_stop2} !== 7'b1000_000) begin n_fail++; $display("FAIL reset_cfg: got %b expected 1000000", {o_len, o_parity_en, o_parity_ty, o_stop2}); end
    n_checks++; if ({o_valid, o_count, o_data} !== 13'h0) begin n_fail++; $display("FAIL reset_fifo: got valid=%b count=%0d data=%h expected 0/0/000", o_valid, o_count, o_data); end
    n_checks++; if ({o_overrun, o_timeout, o_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {o_overrun, o_timeout, o_busy}); end
    rst = 0;
    tick(1);
    n_checks++; if (o_rx_rst !== 1'b0) begin n_fail++; $display("FAIL release_rx_rst: got %b expected 0", o_rx_rst); end
  endtask

  task automatic test_basic;
    write_cfg(4'd8, 0, 0, 0);
    i_ready = 1;
    tick(1);
    i_ready = 0;
    n_checks++; if ({o_valid, o_count} !== 4'h0) begin n_fail++; $display("FAIL pop_empty: got valid=%b count=%0d expected 0/0", o_valid, o_count); end
    i_en = 1;
    tick(1);
    n_checks++; if (o_state !== RX_ARMED || o_rx_str !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL armed: got state=%0d str=%b busy=%b expected 1/1/0", o_state, o_rx_str, o_busy); end
    i_line = 0;
    tick(1);
    i_line = 1;
    n_checks++; if (o_state !== RX_BUSY || o_busy !== 1'b1) begin n_fail++; $display("FAIL busy: got state=%0d busy=%b expected 2/1", o_state, o_busy); end
    tick(150);
    i_rx_data = 8'hA5; i_rx_er = 0; i_rx_done = 1;
    tick(1);
    i_rx_done = 0;
    n_checks++; if (o_valid !== 1'b1 || o_data !== 9'h0A5 || o_count !== 3'd1) begin n_fail++; $display("FAIL basic_push: got valid=%b data=%h count=%0d expected 1/0a5/1", o_valid, o_data, o_count); end
    n_checks++; if (o_busy !== 1'b0 || o_state !== RX_ARMED) begin n_fail++; $display("FAIL basic_after: got busy=%b state=%0d expected 0/1", o_busy, o_state); end
    i_ready = 1;
    tick(1);
    i_ready = 0;
    n_checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin n_fail++; $display("FAIL basic_pop: got valid=%b count=%0d expected 0/0", o_valid, o_count); end
  endtask

  task automatic test_parity;
    i_en = 0;
    tick(1);
    write_cfg(4'd8, 1, 0, 0);
    n_checks++; if (o_parity_en !== 1'b1 || o_parity_ty !== 1'b0) begin n_fail++; $display("FAIL parity_cfg: got en=%b ty=%b expected 1/0", o_parity_en, o_parity_ty); end
    i_en = 1;
    tick(1);
    send_frame(8'h03, 1'b1, 170);
    send_frame(8'h55, 1'b0, 170);
    n_checks++; if (o_count !== 3'd2 || o_data !== 9'h103) begin n_fail++; $display("FAIL parity_err: got count=%0d data=%h expected 2/103", o_count, o_data); end
    i_ready = 1;
    tick(1);
    i_ready = 0;
    n_checks++; if (o_data !== 9'h055) begin n_fail++; $display("FAIL parity_ok: got %h expected 055", o_data); end
    i_ready = 1;
    tick(1);
    i_ready = 0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL parity_drain: got valid=%b expected 0", o_valid); end
  endtask

  task automatic test_overrun;
    i_ready = 0;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 20);
    n_checks++; if (o_count !== 3'd4 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL fill: got count=%0d ovr=%b expected 4/0", o_count, o_overrun); end
    // Fifth char dropped; clear in the same cycle loses to the set.
    i_line = 0; tick(1); i_line = 1; tick(20);
    i_rx_data = 8'h14; i_rx_er = 0; i_rx_done = 1; i_flag_clr = 1;
    tick(1);
    i_rx_done = 0; i_flag_clr = 0;
    n_checks++; if (o_count !== 3'd4 || o_overrun !== 1'b1 || o_data !== 9'h010) begin n_fail++; $display("FAIL overrun: got count=%0d ovr=%b head=%h expected 4/1/010", o_count, o_overrun, o_data); end
    i_flag_clr = 1;
    tick(1);
    i_flag_clr = 0;
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: got %b expected 0", o_overrun); end
    // Push and pop together while full.
    i_line = 0; tick(1); i_line = 1; tick(20);
    i_rx_data = 8'h20; i_rx_done = 1; i_ready = 1;
    tick(1);
    i_rx_done = 0; i_ready = 0;
    n_checks++; if (o_count !== 3'd4 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL full_pushpop: got count=%0d ovr=%b expected 4/0", o_count, o_overrun); end
    exp_q = {9'h011, 9'h012, 9'h013, 9'h020};
    for (int i = 0; i < 4; i++) begin
      exp_v = exp_q.pop_front();
      n_checks++; if (o_valid !== 1'b1 || o_data !== exp_v) begin n_fail++; $display("FAIL drain[%0d]: got valid=%b data=%h expected 1/%h", i, o_valid, o_data, exp_v); end
      i_ready = 1;
      tick(1);
      i_ready = 0;
    end
    n_checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin n_fail++; $display("FAIL drain_end: got valid=%b count=%0d expected 0/0", o_valid, o_count); end
  endtask

  task automatic test_watchdog;
    i_line = 0;
    tick(1);
    n_checks++; if (o_state !== RX_BUSY) begin n_fail++; $display("FAIL wd_enter: got %0d expected 2", o_state); end
    tick(3);
    i_line = 1;
    tick(TIMEOUT - 4);
    n_checks++; if (o_state !== RX_BUSY || o_rx_rst !== 1'b0 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_last: got state=%0d rxrst=%b to=%b expected 2/0/0", o_state, o_rx_rst, o_timeout); end
    tick(1);
    n_checks++; if (o_state !== RX_ABORT || o_rx_rst !== 1'b1 || o_rx_str !== 1'b0 || o_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_abort: got state=%0d rxrst=%b str=%b to=%b expected 3/1/0/1", o_state, o_rx_rst, o_rx_str, o_timeout); end
    tick(1);
    n_checks++; if (o_state !== RX_ARMED || o_rx_rst !== 1'b0 || o_rx_str !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL wd_rearm: got state=%0d rxrst=%b str=%b valid=%b expected 1/0/1/0", o_state, o_rx_rst, o_rx_str, o_valid); end
    i_flag_clr = 1;
    tick(1);
    i_flag_clr = 0;
    n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %b expected 0", o_timeout); end
  endtask

  task automatic test_done_priority;
    i_line = 0;
    tick(1);
    i_line = 1;
    tick(TIMEOUT - 1);
    // Last watchdog cycle with disable also asserted: done wins.
    i_rx_data = 8'h3C; i_rx_er = 0; i_rx_done = 1; i_en = 0;
    tick(1);
    i_rx_done = 0;
    n_checks++; if (o_state !== RX_ARMED || o_timeout !== 1'b0 || o_valid !== 1'b1 || o_data !== 9'h03C) begin n_fail++; $display("FAIL done_prio: got state=%0d to=%b valid=%b data=%h expected 1/0/1/03c", o_state, o_timeout, o_valid, o_data); end
    i_ready = 1;
    tick(1);
    i_ready = 0;
    n_checks++; if (o_state !== RX_OFF || o_valid !== 1'b0) begin n_fail++; $display("FAIL done_prio_off: got state=%0d valid=%b expected 0/0", o_state, o_valid); end
  endtask

  task automatic test_disable;
    i_en = 1;
    tick(1);
    i_line = 0;
    tick(1);
    i_line = 1;
    tick(56);
    write_cfg(4'd5, 0, 0, 0);
    n_checks++; if (o_len !== 4'd8) begin n_fail++; $display("FAIL cfg_busy_ignored: got %0d expected 8", o_len); end
    i_en = 0;
    tick(1);
    n_checks++; if (o_state !== RX_ABORT || o_rx_rst !== 1'b1 || o_busy !== 1'b1 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL dis_abort: got state=%0d rxrst=%b busy=%b to=%b expected 3/1/1/0", o_state, o_rx_rst, o_busy, o_timeout); end
    tick(1);
    n_checks++; if (o_state !== RX_OFF || o_busy !== 1'b0 || o_rx_str !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL dis_off: got state=%0d busy=%b str=%b valid=%b expected 0/0/0/0", o_state, o_busy, o_rx_str, o_valid); end
    write_cfg(4'd5, 0, 0, 0);
    n_checks++; if (o_len !== 4'd5) begin n_fail++; $display("FAIL cfg_off: got %0d expected 5", o_len); end
  endtask

  task automatic test_reset_mid;
    write_cfg(4'd7, 1, 1, 1);
    i_en = 1;
    tick(1);
    send_frame(8'h61, 1'b0, 30);
    send_frame(8'h62, 1'b1, 30);
    i_line = 0;
    tick(1);
    i_line = 1;
    n_checks++; if (o_count !== 3'd2 || o_state !== RX_BUSY) begin n_fail++; $display("FAIL pre_reset: got count=%0d state=%0d expected 2/2", o_count, o_state); end
    rst = 1;
    tick(1);
    n_checks++; if (o_state !== RX_OFF || o_rx_rst !== 1'b1 || o_rx_str !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: got state=%0d rxrst=%b str=%b busy=%b expected 0/1/0/0", o_state, o_rx_rst, o_rx_str, o_busy); end
    n_checks++; if ({o_valid, o_count, o_data} !== 13'h0) begin n_fail++; $display("FAIL mid_reset_fifo: got valid=%b count=%0d data=%h expected 0/0/000", o_valid, o_count, o_data); end
    n_checks++; if ({o_len, o_parity_en, o_parity_ty, o_stop2} !== 7'b1000_000) begin n_fail++; $display("FAIL mid_reset_cfg: got %b expected 1000000", {o_len, o_parity_en, o_parity_ty, o_stop2}); end
    i_en = 0;
    rst = 0;
    tick(1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_overrun();
    test_watchdog();
    test_done_priority();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that owns and sequences one `uart_rx` instance. It holds the frame configuration and arms reception. It supervises each frame with a watchdog and aborts the receiver when needed. Each completed character is captured with its error flag into a small FIFO for the host logic. It sits between the oversampled `uart_rx` and the consumer.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 256: max `i_rx_clk` cycles from start-bit detection to `i_rx_done`. Must be ≥192, the longest frame: 12 bits × 16.

Ports:
- `i_rx_clk`  in  1  16× oversample clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `i_en`  in  1  reception enable.
- `i_cfg_wr`  in  1  config write strobe.
- `i_cfg_len`, `i_cfg_parity_en`, `i_cfg_parity_ty`, `i_cfg_stop2`  in  4/1/1/1  new config values.
- `o_len`, `o_parity_en`, `o_parity_ty`, `o_stop2`  out  4/1/1/1  registered config driven to `uart_rx`.
- `o_rx_str`  out  1  arm strobe to `uart_rx`.
- `o_rx_rst`  out  1  reset to `uart_rx` (`rst` OR abort).
- `i_line`  in  1  raw serial line (same signal as `uart_rx` `i_rx`).
- `i_rx_data`  in  8  `uart_rx` `o_rx`.
- `i_rx_done`  in  1  `uart_rx` `o_rx_done`.
- `i_rx_er`  in  1  `uart_rx` `o_rx_er`.
- `o_data`  out  9  FIFO head `{er, data}`.
- `o_valid`  out  1  FIFO non-empty.
- `i_ready`  in  1  consumer pop.
- `o_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `o_overrun`  out  1  sticky; set when a char is dropped because the FIFO is full.
- `o_timeout`  out  1  sticky; set on watchdog abort.
- `i_flag_clr`  in  1  clears `o_overrun` and `o_timeout`.
- `o_busy`  out  1  high in `BUSY` or `ABORT`.

## Operation
States: `OFF`, `ARMED`, `BUSY`, `ABORT`.
- `OFF`:
  - `o_rx_str`=0.
  - `i_cfg_wr` latches all four cfg fields; `i_cfg_wr` is ignored in every other state.
  - `i_en`=1 → `ARMED`.
- `ARMED`:
  - `o_rx_str`=1.
  - `i_en`=0 → `OFF`.
  - `i_line`=0 → `BUSY`; watchdog cleared to 0.
- `BUSY`:
  - `o_rx_str`=1; watchdog increments each cycle.
  - `i_rx_done`=1 → push `{i_rx_er, i_rx_data}`, go to `ARMED`.
  - `i_en`=0 → `ABORT`.
  - watchdog = `TIMEOUT`-1 without done → `ABORT`, set `o_timeout`.
  - Done takes priority over both abort causes in the same cycle.
  - A false start bit (receiver silently returns to idle) is recovered only via the watchdog.
- `ABORT`:
  - exactly one cycle; `o_rx_rst`=1, `o_rx_str`=0, no push.
  - Next state is `ARMED` if `i_en` else `OFF`.
- FIFO rules:
  - push when full → entry dropped, `o_overrun` set.
  - pop when `o_valid`=0 → ignored.
  - push and pop in the same cycle when full → both succeed; count unchanged, no overrun.
- Flag precedence: a flag set condition in the same cycle as `i_flag_clr` wins, so the flag stays 1.
- Config defaults: len=8, parity_en=0, parity_ty=0, stop2=0.

## Timing
- Reset values:
  - state `OFF`; `o_rx_str`=0; `o_rx_rst`=1 while `rst`.
  - config outputs at defaults.
  - `o_valid`=0, `o_count`=0, `o_data`=0.
  - `o_overrun`=0, `o_timeout`=0, `o_busy`=0.
- Reset mid-frame discards the frame and empties the FIFO.
- All outputs are registered except `o_rx_rst` (combinational OR) and `o_data` (registered-array head read).
- Push latency: `i_rx_done` high at edge N → `o_valid`=1 and `o_data` valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Pop: `o_valid & i_ready` at edge M → head advances and `o_count` decrements after M.
- `ARMED`→`BUSY` transitions on the same edge at which `uart_rx` leaves idle.
- Config outputs change only on an edge with state `OFF` and `i_cfg_wr`=1; they are stable throughout any frame.
- Pointers wrap modulo `DEPTH`; `o_count` ranges 0..`DEPTH`.

## Structure
- Package `uart_pkg` holds:
  - `rx_ctrl_state_t` enum.
  - `uart_cfg_t` packed struct (len, parity_en, parity_ty, stop2).
  - constants `UART_OSR`=16 and `UART_MAX_FRAME_TICKS`=192.
  - `UART_CFG_DEFAULT`.
- Sub-module `uart_rx_fifo`: synchronous FIFO, parameters WIDTH=9 and DEPTH, ports push/pop/full/empty/count.

## Test plan
- **Basic receive:** cfg len=8, no parity; enable; receive 0xA5 → one entry `{0,0xA5}`, `o_valid` 1 cycle after done, `o_busy` low afterwards.
- **Parity error:** cfg even parity; send 0x03 with wrong parity bit → entry `{1,0x03}`; next frame 0x55 with correct parity → `{0,0x55}`.
- **Overrun:** `DEPTH`=4, `i_ready`=0; send 5 chars 0x10..0x14 → `o_count`=4, FIFO holds 0x10..0x13, `o_overrun`=1. Then push and pop on the same edge → count stays 4, no new overrun.
- **False start / watchdog:** drive `i_line` low for 4 cycles then high → `ABORT` exactly `TIMEOUT` cycles after entry to `BUSY`, `o_rx_rst` pulse of 1 cycle, `o_timeout`=1, back to `ARMED`, no push.
- **Disable mid-frame:** drop `i_en` at data bit 3 → `ABORT` then `OFF`, no push. A `i_cfg_wr` with len=5 asserted during `BUSY` is ignored; the same write in `OFF` updates `o_len` to 5.
- **Reset:** assert `rst` with 2 entries queued and a frame in flight → all outputs at reset values the next cycle.
